// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared widths, limits and FSM state encoding for the accelerometer scaler
package accel_pkg;
    localparam int RAW_W = 16;
    localparam int OUT_W = 24;
    localparam logic [OUT_W-1:0] OUT_MAX = 24'hFFFFFF;

    typedef logic [0:0] state_t;
    localparam state_t ST_CAL = 1'b0;
    localparam state_t ST_RUN = 1'b1;
endpackage

// File: rtl/accel_axis_path.sv
// rtl/accel_axis_path.sv - one axis: offset learning accumulator, offset register, diff/abs/scale pipeline
module accel_axis_path
    import accel_pkg::*;
#(
    parameter int          CAL_LOG2 = 10,
    parameter logic [15:0] SCALE    = 16'd4,
    parameter int          SHIFT    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [RAW_W-1:0] i_raw,
    input  logic             i_clear,
    input  logic             i_acc_en,
    input  logic             i_latch_offset,
    input  logic             i_load,
    output logic [OUT_W-1:0] o_data
);
    localparam int AW = RAW_W + CAL_LOG2;

    logic signed [AW-1:0]    r_acc;
    logic signed [AW-1:0]    w_acc_sum;
    logic [RAW_W-1:0]        r_off;
    logic [RAW_W:0]          r_diff;
    logic [RAW_W-1:0]        r_mag;
    logic [RAW_W-1:0]        w_mag;
    logic [31:0]             w_prod;
    logic [OUT_W-1:0]        w_sat;
    logic [OUT_W-1:0]        r_out;

    assign w_acc_sum = r_acc + {{CAL_LOG2{i_raw[RAW_W-1]}}, i_raw};
    assign w_mag     = r_diff[RAW_W] ? RAW_W'(-r_diff) : r_diff[RAW_W-1:0];
    assign w_prod    = (32'(r_mag) * 32'(SCALE)) >> SHIFT;
    // Anything above bit 23 means the magnitude no longer fits Q8.16
    assign w_sat     = (|w_prod[31:OUT_W]) ? OUT_MAX : w_prod[OUT_W-1:0];
    assign o_data    = r_out;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc  <= '0;
            r_off  <= '0;
            r_diff <= '0;
            r_mag  <= '0;
            r_out  <= '0;
        end else begin
            if (i_clear || i_latch_offset) begin
                r_acc <= '0;
            end else if (i_acc_en) begin
                r_acc <= w_acc_sum;
            end
            // Taking bits [L+15:L] of the full sum is the floor-divided mean
            if (i_latch_offset) begin
                r_off <= w_acc_sum[CAL_LOG2 +: RAW_W];
            end
            r_diff <= {i_raw[RAW_W-1], i_raw} - {r_off[RAW_W-1], r_off};
            r_mag  <= w_mag;
            if (i_clear) begin
                r_out <= '0;
            end else if (i_load) begin
                r_out <= w_sat;
            end
        end
    end
endmodule

// File: rtl/accel_scaler.sv
// rtl/accel_scaler.sv - calibrate/run FSM and valid tracking around three axis paths
module accel_scaler
    import accel_pkg::*;
#(
    parameter int          CAL_LOG2 = 10,
    parameter logic [15:0] SCALE    = 16'd4,
    parameter int          SHIFT    = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [RAW_W-1:0] i_xraw,
    input  logic [RAW_W-1:0] i_yraw,
    input  logic [RAW_W-1:0] i_zraw,
    input  logic             i_recal,
    output logic [OUT_W-1:0] o_xdata_scaled,
    output logic [OUT_W-1:0] o_ydata_scaled,
    output logic [OUT_W-1:0] o_zdata_scaled,
    output logic             o_valid,
    output logic             o_cal_done
);
    localparam logic [CAL_LOG2:0] CNT_ONE = 1;

    state_t            r_state;
    logic [CAL_LOG2:0] r_cnt;
    logic [CAL_LOG2:0] w_cnt_next;
    logic [1:0]        r_vld;
    logic              r_ovalid;
    logic              w_cal_vld;
    logic              w_last;
    logic              w_acc_en;
    logic              w_load;

    // A recal in the same cycle as a sample discards that sample
    assign w_cal_vld  = i_valid && !i_recal && (r_state == ST_CAL);
    assign w_cnt_next = r_cnt + CNT_ONE;
    assign w_last     = w_cal_vld && w_cnt_next[CAL_LOG2];
    assign w_acc_en   = w_cal_vld && !w_last;
    assign w_load     = r_vld[1] && !i_recal;
    assign o_valid    = r_ovalid;
    assign o_cal_done = (r_state == ST_RUN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_CAL;
            r_cnt    <= '0;
            r_vld    <= '0;
            r_ovalid <= 1'b0;
        end else if (i_recal) begin
            r_state  <= ST_CAL;
            r_cnt    <= '0;
            r_vld    <= '0;
            r_ovalid <= 1'b0;
        end else begin
            if (w_last) begin
                r_state <= ST_RUN;
                r_cnt   <= '0;
            end else if (w_cal_vld) begin
                r_cnt <= w_cnt_next;
            end
            r_vld    <= {r_vld[0], i_valid && (r_state == ST_RUN)};
            r_ovalid <= r_vld[1];
        end
    end

    accel_axis_path #(.CAL_LOG2(CAL_LOG2), .SCALE(SCALE), .SHIFT(SHIFT)) u_x (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_xraw), .i_clear(i_recal),
        .i_acc_en(w_acc_en), .i_latch_offset(w_last), .i_load(w_load),
        .o_data(o_xdata_scaled)
    );
    accel_axis_path #(.CAL_LOG2(CAL_LOG2), .SCALE(SCALE), .SHIFT(SHIFT)) u_y (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_yraw), .i_clear(i_recal),
        .i_acc_en(w_acc_en), .i_latch_offset(w_last), .i_load(w_load),
        .o_data(o_ydata_scaled)
    );
    accel_axis_path #(.CAL_LOG2(CAL_LOG2), .SCALE(SCALE), .SHIFT(SHIFT)) u_z (
        .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_zraw), .i_clear(i_recal),
        .i_acc_en(w_acc_en), .i_latch_offset(w_last), .i_load(w_load),
        .o_data(o_zdata_scaled)
    );
endmodule

// File: tb/tb_accel_scaler.sv
// tb/tb_accel_scaler.sv - vector table plus scoreboard bench for accel_scaler
module tb_accel_scaler;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_recal = 1'b0;
    logic [15:0] i_xraw = '0, i_yraw = '0, i_zraw = '0;
    logic [23:0] o_x, o_y, o_z;
    logic        o_valid, o_cal_done;

    logic        s_valid = 1'b0;
    logic [15:0] s_xraw = '0, s_yraw = '0;
    logic [23:0] s_x, s_y, s_z;
    logic        s_ovalid, s_cal_done;

    typedef struct {
        logic [23:0] x, y, z;
        int          due;
    } exp_t;
    typedef struct {
        logic [15:0] x, y, z;
        logic [23:0] ex, ey, ez;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[5];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    accel_scaler #(.CAL_LOG2(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid),
        .i_xraw(i_xraw), .i_yraw(i_yraw), .i_zraw(i_zraw), .i_recal(i_recal),
        .o_xdata_scaled(o_x), .o_ydata_scaled(o_y), .o_zdata_scaled(o_z),
        .o_valid(o_valid), .o_cal_done(o_cal_done)
    );

    accel_scaler #(.CAL_LOG2(4), .SCALE(16'd512), .SHIFT(0)) dut_sat (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(s_valid),
        .i_xraw(s_xraw), .i_yraw(s_yraw), .i_zraw(16'd0), .i_recal(1'b0),
        .o_xdata_scaled(s_x), .o_ydata_scaled(s_y), .o_zdata_scaled(s_z),
        .o_valid(s_ovalid), .o_cal_done(s_cal_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_o_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("x_out", {8'd0, o_x}, {8'd0, e.x});
                chk("y_out", {8'd0, o_y}, {8'd0, e.y});
                chk("z_out", {8'd0, o_z}, {8'd0, e.z});
                chk("latency_cycle", cyc, e.due);
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        i_valid = 1'b1;
        i_xraw = x; i_yraw = y; i_zraw = z;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic meas(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [23:0] ex, input logic [23:0] ey, input logic [23:0] ez);
        exp_t e;
        e.x = ex; e.y = ey; e.z = ez; e.due = cyc + 3;
        sb_q.push_back(e);
        send(x, y, z);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic calib(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        repeat (15) send(x, y, z);
        chk("cal_done_before_last", {31'd0, o_cal_done}, 32'd0);
        send(x, y, z);
        chk("cal_done_after_last", {31'd0, o_cal_done}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{x:16'd20480, y:16'd0,     z:-16'sd300,  ex:24'h004000, ey:24'h000000, ez:24'h000320};
        vecs[1] = '{x:16'd16384, y:16'd0,     z:-16'sd100,  ex:24'h000000, ey:24'h000000, ez:24'h000000};
        vecs[2] = '{x:16'd0,     y:16'hFFFF,  z:16'd100,    ex:24'h010000, ey:24'h000004, ez:24'h000320};
        vecs[3] = '{x:16'h8000,  y:16'd32767, z:16'd32767,  ex:24'h030000, ey:24'h01FFFC, ez:24'h02018C};
        vecs[4] = '{x:16'd32767, y:16'h8000,  z:16'h8000,   ex:24'h00FFFC, ey:24'h020000, ez:24'h01FE70};

        idle(3);
        chk("rst_x", {8'd0, o_x}, 32'd0);
        chk("rst_y", {8'd0, o_y}, 32'd0);
        chk("rst_z", {8'd0, o_z}, 32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_cal_done", {31'd0, o_cal_done}, 32'd0);
        i_rst = 1'b0;

        s_valid = 1'b1;
        idle(16);
        chk("sat_cal_done", {31'd0, s_cal_done}, 32'd1);
        s_xraw = 16'h8000; s_yraw = 16'd100;
        idle(1);
        s_valid = 1'b0;
        idle(2);
        chk("sat_valid", {31'd0, s_ovalid}, 32'd1);
        chk("sat_x", {8'd0, s_x}, 32'h00FFFFFF);
        chk("sat_y", {8'd0, s_y}, 32'h0000C800);
        idle(1);
        chk("sat_valid_pulse", {31'd0, s_ovalid}, 32'd0);
        chk("sat_x_hold", {8'd0, s_x}, 32'h00FFFFFF);

        calib(16'd16384, 16'd0, -16'sd100);
        for (int i = 0; i < 5; i++) begin
            meas(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].ex, vecs[i].ey, vecs[i].ez);
            if (i < 2) idle(2);
        end
        idle(6);
        chk("hold_x", {8'd0, o_x}, {8'd0, vecs[4].ex});
        chk("hold_valid_low", {31'd0, o_valid}, 32'd0);

        for (int k = 1; k <= 5; k++)
            meas(16'(16384 + k), 16'd0, -16'sd100, 24'(4 * k), 24'd0, 24'd0);
        idle(5);

        send(16'd16386, 16'd0, 16'd0);
        send(16'd16387, 16'd0, 16'd0);
        i_recal = 1'b1; i_valid = 1'b1; i_xraw = 16'd30000;
        @(posedge i_clk); #1;
        i_recal = 1'b0; i_valid = 1'b0;
        chk("recal_cal_done", {31'd0, o_cal_done}, 32'd0);
        chk("recal_x_clear", {8'd0, o_x}, 32'd0);
        chk("recal_valid", {31'd0, o_valid}, 32'd0);
        idle(4);
        calib(16'd1000, -16'sd2000, 16'd3);
        meas(16'd1005, -16'sd2010, -16'sd7, 24'd20, 24'd40, 24'd40);
        idle(5);

        chk("pre_reset_nonzero", {8'd0, o_x}, 32'd20);
        @(posedge i_clk); #3;
        i_rst = 1'b1;
        #1;
        chk("async_rst_x", {8'd0, o_x}, 32'd0);
        chk("async_rst_y", {8'd0, o_y}, 32'd0);
        chk("async_rst_cal_done", {31'd0, o_cal_done}, 32'd0);
        chk("async_rst_valid", {31'd0, o_valid}, 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        calib(-16'sd5, 16'd7, 16'd0);
        meas(16'd95, 16'd7, -16'sd1, 24'h000190, 24'd0, 24'd4);
        idle(6);
        chk("scoreboard_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/accel_scaler.md
# accel_scaler

Front-end conditioning block that produces the `i_xdata_scaled` / `i_ydata_scaled` / `i_zdata_scaled` magnitudes consumed by the WBCAV alarm logic.
- Takes signed 16-bit raw accelerometer samples per axis.
- Learns and removes the static per-axis offset (gravity and bias) during a calibration phase.
- Outputs unsigned 24-bit Q8.16 g-unit magnitudes.
- Outputs hold between samples, so the 1 kHz-domain consumer can sample them at any time.

## Interface
- `CAL_LOG2`, default 10: calibration length is 2^CAL_LOG2 valid samples.
- `SCALE`, default 16'd4: unsigned gain applied to |raw − offset|. Default maps 16384 LSB/g to Q8.16.
- `SHIFT`, default 0: right shift after the gain multiply.

Ports:
- `i_clk` in 1: system clock, single clock domain.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_valid` in 1: one-cycle strobe; raw x/y/z are valid in this cycle.
- `i_xraw`, `i_yraw`, `i_zraw` in 16 each: signed two's-complement raw samples.
- `i_recal` in 1: one-cycle request to restart calibration.
- `o_xdata_scaled`, `o_ydata_scaled`, `o_zdata_scaled` out 24 each: unsigned Q8.16 magnitudes, held until the next update.
- `o_valid` out 1: one-cycle pulse when the outputs update.
- `o_cal_done` out 1: high while in RUN.

## Operation
- State machine with two states, CAL and RUN. Reset and `i_recal` both enter CAL.
- CAL:
  - Each `i_valid` adds the sign-extended raw sample to a per-axis signed accumulator of (16+CAL_LOG2) bits and increments a CAL_LOG2+1-bit counter.
  - When the counter reaches 2^CAL_LOG2, offset = accumulator >>> CAL_LOG2 (arithmetic shift, floor). Accumulator and counter clear, and the state moves to RUN on the next cycle.
  - Outputs stay 0 and `o_valid` stays 0 throughout CAL.
- RUN, 3-stage pipeline per axis:
  - S1: diff = raw − offset, 17-bit signed.
  - S2: mag = |diff|, 16-bit unsigned. Maximum 65535, so no overflow.
  - S3: prod = (mag × SCALE) >> SHIFT, 32-bit intermediate, saturated to 24'hFFFFFF. Result is registered into the outputs and `o_valid` pulses.
- A valid-bit shift register tracks samples through the pipeline. Back-to-back `i_valid` is accepted every cycle; there is no backpressure.
- `i_recal` in RUN:
  - Next cycle: state is CAL, the pipeline valid bits are flushed, outputs go to 0, and `o_cal_done` is 0.
  - In-flight samples never produce an `o_valid`.
- `i_recal` and `i_valid` in the same cycle: recalibration wins and that sample is discarded (not accumulated).
- `i_recal` during CAL: accumulator and counter restart from zero.
- The offset registers keep their previous value until the new calibration completes. They are not used during CAL.

## Timing
- Reset values:
  - All three outputs 0.
  - `o_valid` 0, `o_cal_done` 0.
  - State CAL, accumulators, counter, offsets and pipeline valid bits all 0.
- Reset is asynchronous assert. Deassertion is assumed synchronous to `i_clk` upstream.
- RUN latency: `i_valid` at cycle N gives outputs updated and `o_valid`=1 at cycle N+3.
- CAL completion: the final calibration `i_valid` at cycle N gives `o_cal_done`=1 from cycle N+1. The first usable `i_valid` is at N+1.
- Throughput is one sample per clock.
- Outputs change only on the `o_valid` cycle, on a recal, or on reset. This guarantees stable values for the slower consumer clock.

## Structure
- Shared package `accel_pkg`:
  - `RAW_W`=16, `OUT_W`=24, `OUT_MAX`=24'hFFFFFF.
  - State typedef {CAL, RUN}.
- Sub-module `accel_axis_path`: per-axis accumulator, offset register and the 3-stage pipeline, instantiated three times.
- The top level holds the FSM, calibration counter and valid shift register, and drives `clear` / `latch_offset` / `run` to each axis instance.

## Test plan
- Reset mid-operation:
  - Stimulus: assert `i_rst` asynchronously while in RUN with nonzero outputs.
  - Required response: outputs, `o_valid` and `o_cal_done` go to 0 immediately, and the next 2^CAL_LOG2 samples recalibrate.
- Calibration then measure, with CAL_LOG2=4:
  - Stimulus: 16 samples of x=16384, y=0, z=−100, then x=20480, y=0, z=−300.
  - Required response: `o_cal_done` rises after sample 16. Three cycles after the measurement sample: x=24'h004000, y=0, z=24'h000320, with a one-cycle `o_valid`.
- Back-to-back:
  - Stimulus: 5 consecutive `i_valid` cycles in RUN with x offsets 1..5.
  - Required response: 5 consecutive `o_valid` pulses; x outputs 4, 8, 12, 16, 20.
- Saturation:
  - Stimulus: SCALE=512, offset 0, x=−32768.
  - Required response: x output = 24'hFFFFFF. Negative full-scale handled with correct abs.
- Recal collision:
  - Stimulus: `i_recal` and `i_valid` in the same cycle with two samples still in flight.
  - Required response: no further `o_valid`, outputs 0 next cycle, and the colliding sample is not counted toward the 16 calibration samples.
